// File: rtl/spi_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_ctrl_pkg
// Brief   : Shared types and constants for the SPI mode-0 master controller.
// Revision: 1.0 - initial release
// ============================================================================
package spi_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } state_e;

    localparam int SPI_MODE = 0;

    // Wide enough to hold DATA_W itself, so the last bit index never wraps.
    function automatic int bit_cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ============================================================================
// Module  : spi_clk_div
// Brief   : Half-period tick generator; one tick every div+1 enabled cycles.
// Revision: 1.0 - initial release
// ============================================================================
module spi_clk_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;

    // Counter only ever reaches div, so div = all-ones never overflows it.
    assign tick = en && !load && (cnt_q == div);

    always_ff @(posedge clk) begin
        if (rst || load || !en) begin
            cnt_q <= '0;
        end else if (cnt_q == div) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : spi_master_ctrl
// Brief   : SPI mode-0 master; one MSB-first transfer per accepted start.
// Revision: 1.0 - initial release
// ============================================================================
module spi_master_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [DIV_W-1:0]  div,
    input  logic              miso,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    localparam int            BCW  = bit_cnt_w(DATA_W);
    localparam logic [BCW-1:0] LAST = BCW'(DATA_W - 1);

    state_e              state_q;
    logic [DIV_W-1:0]    div_q;
    logic [BCW-1:0]      bit_cnt_q;
    logic [DATA_W-2:0]   tx_sh_q;
    logic [DATA_W-1:0]   rx_sh_q;
    logic                sclk_q;
    logic                cs_n_q;
    logic                mosi_q;
    logic                busy_q;
    logic                done_q;
    logic [DATA_W-1:0]   rx_data_q;

    logic                w_load;
    logic                w_tick;

    assign w_load = (state_q == IDLE) && start;

    spi_clk_div #(
        .DIV_W (DIV_W)
    ) u_clk_div (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != IDLE),
        .load (w_load),
        .div  (div_q),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_cnt_q <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        div_q     <= div;
                        tx_sh_q   <= tx_data[DATA_W-2:0];
                        mosi_q    <= tx_data[DATA_W-1];
                        bit_cnt_q <= '0;
                        cs_n_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= LEAD;
                    end
                end
                LEAD: begin
                    if (w_tick) state_q <= XFER;
                end
                XFER: begin
                    if (w_tick) begin
                        if (!sclk_q) begin
                            sclk_q  <= 1'b1;
                            rx_sh_q <= {rx_sh_q[DATA_W-2:0], miso};
                        end else begin
                            sclk_q <= 1'b0;
                            // Last falling edge: mosi keeps the final bit.
                            if (bit_cnt_q == LAST) begin
                                state_q <= TRAIL;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                                mosi_q    <= tx_sh_q[DATA_W-2];
                                tx_sh_q   <= {tx_sh_q[DATA_W-3:0], 1'b0};
                            end
                        end
                    end
                end
                TRAIL: begin
                    if (w_tick) begin
                        cs_n_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        rx_data_q <= rx_sh_q;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sclk    = sclk_q;
    assign cs_n    = cs_n_q;
    assign mosi    = mosi_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_master_ctrl
// Brief   : Self-checking bench for spi_master_ctrl with a behavioural slave.
// Revision: 1.0 - initial release
// ============================================================================
module tb_spi_master_ctrl;

    localparam int DW = 8;
    localparam int VW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          miso = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic [VW-1:0] div = '0;
    logic          sclk, cs_n, mosi, busy, done;
    logic [DW-1:0] rx_data;

    logic [DW-1:0] exp_tx, exp_sl;
    int            exp_h;
    int            n_chk = 0;
    int            n_pass = 0;

    spi_master_ctrl #(.DATA_W(DW), .DIV_W(VW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .tx_data (tx_data),
        .div     (div),
        .miso    (miso),
        .sclk    (sclk),
        .cs_n    (cs_n),
        .mosi    (mosi),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    endtask

    // Request a transfer; the slave presents its MSB before the first rise.
    task automatic kick(input logic [DW-1:0] tx, input logic [VW-1:0] dv, input logic [DW-1:0] sl);
        exp_tx  = tx;
        exp_sl  = sl;
        exp_h   = int'(dv) + 1;
        tx_data = tx;
        div     = dv;
        miso    = sl[DW-1];
        start   = 1'b1;
    endtask

    // Follow one transfer from the accepting edge up to the done pulse.
    task automatic watch(input bit poke);
        int h, lim, rises, falls, low, bad, done_at;
        logic [DW-1:0] got;
        logic ps;
        h = exp_h; lim = (2*DW+2)*h + 20;
        rises = 0; falls = 0; bad = 0; done_at = -1; got = '0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("accept_cs_n", cs_n, 0);
        chk("accept_busy", busy, 1);
        chk("accept_mosi", mosi, exp_tx[DW-1]);
        chk("accept_done", done, 0);
        low = 1; ps = sclk;
        for (int c = 1; c <= lim; c++) begin
            @(posedge clk); #1;
            if (poke && c == 5*h) begin
                start = 1'b1; tx_data = ~exp_tx; div = VW'(exp_h + 2);
            end else if (poke && c == 5*h + 1) begin
                start = 1'b0;
            end
            if (done) begin done_at = c; break; end
            if (sclk && !ps) begin
                if (c != (2 + 2*rises)*h) bad++;
                got = {got[DW-2:0], mosi};
                rises++;
            end
            if (!sclk && ps) begin
                if (c != (3 + 2*falls)*h) bad++;
                falls++;
                if (falls < DW) miso = exp_sl[DW-1-falls];
            end
            if (!busy || cs_n) bad++;
            if (!cs_n) low++;
            ps = sclk;
        end
        chk("done_latency", done_at, (2*DW+2)*h);
        chk("rx_data", rx_data, exp_sl);
        chk("mosi_stream", got, exp_tx);
        chk("sclk_rises", rises, DW);
        chk("sclk_falls", falls, DW);
        chk("edge_timing", bad, 0);
        chk("cs_n_low_cycles", low, (2*DW+2)*h);
        chk("done_cs_n", cs_n, 1);
        chk("done_busy", busy, 0);
        chk("done_sclk", sclk, 0);
        chk("mosi_hold", mosi, exp_tx[0]);
    endtask

    initial begin
        int r, bad;
        logic ps;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sclk", sclk, 0);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_mosi", mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rx", rx_data, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic loopback-equivalent and minimum divider
        kick(8'hA5, 8'd4, 8'hA5); watch(0);
        @(posedge clk); #1;
        kick(8'h3C, 8'd0, 8'hFF); watch(0);

        // Back-to-back: new start in the done cycle
        @(posedge clk); #1;
        kick(DW'($urandom), VW'($urandom_range(0, 3)), DW'($urandom)); watch(0);
        kick(8'h5A, 8'd1, DW'($urandom)); watch(0);

        // Start and input changes while busy are ignored
        @(posedge clk); #1;
        kick(DW'($urandom), 8'd2, 8'h81); watch(1);
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (!cs_n || busy || done) bad++;
        end
        chk("no_extra_xfer", bad, 0);

        // Reset in the middle of XFER
        kick(8'hC3, 8'd2, 8'h96);
        @(posedge clk); #1;
        start = 1'b0; r = 0; ps = sclk;
        for (int c = 0; c < 200 && r < 3; c++) begin
            @(posedge clk); #1;
            if (sclk && !ps) r++;
            ps = sclk;
        end
        chk("rst_mid_rises", r, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmid_sclk", sclk, 0);
        chk("rstmid_cs_n", cs_n, 1);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_rx", rx_data, 0);
        chk("rstmid_mosi", mosi, 0);
        bad = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done || !cs_n || busy) bad++;
        end
        chk("rstmid_quiet", bad, 0);
        kick(DW'($urandom), 8'd1, DW'($urandom)); watch(0);

        // Maximum divider
        @(posedge clk); #1;
        kick(DW'($urandom), 8'd255, DW'($urandom)); watch(0);

        // Randomized transfers
        repeat (4) begin
            @(posedge clk); #1;
            kick(DW'($urandom), VW'($urandom_range(0, 7)), DW'($urandom)); watch(0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
